// File: rtl/null_pages_pkg.sv
// null_pages_pkg: shared widths and types for the free-page list
package null_pages_pkg;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] page_addr_t;
  typedef logic [ADDR_W:0]   page_cnt_t;
endpackage

// File: rtl/null_pages_ram.sv
// null_pages_ram: DEPTH x ADDR_W page store, synchronous write, asynchronous read, no reset
module null_pages_ram #(
  parameter int ADDR_W = null_pages_pkg::ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0] rdata
);
  import null_pages_pkg::*;
  logic [ADDR_W-1:0] mem [DEPTH];
  assign rdata = mem[raddr];
  // store a returned page at the tail slot
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/null_pages_fifo.sv
// null_pages_fifo: free-page FIFO, starts full with pages 0..DEPTH-1; optional sticky err via NULL_PAGES_ERR_EN
module null_pages_fifo #(
  parameter int ADDR_W = null_pages_pkg::ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pop_head,
  output logic [ADDR_W-1:0] head_addr,
  input  logic              push_tail,
  input  logic [ADDR_W-1:0] tail_addr,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef NULL_PAGES_ERR_EN
  ,output logic             err
`endif
);
  import null_pages_pkg::*;
  localparam logic [ADDR_W:0]   FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] head_ptr, tail_ptr, rd_data;
  logic first_lap, pop_ok, push_ok;
  assign pop_ok    = pop_head && count != '0;
  assign push_ok   = push_tail && (count != FULL || pop_ok);
  assign empty     = count == '0;
  assign head_addr = first_lap ? head_ptr : rd_data;
  null_pages_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (tail_ptr),
    .wdata (tail_addr),
    .raddr (head_ptr),
    .rdata (rd_data)
  );
  // pointers, occupancy and the identity-content flag for the first pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      count     <= FULL;
      first_lap <= 1'b1;
    end else begin
      if (pop_ok) head_ptr <= head_ptr + ADDR_W'(1);
      if (pop_ok && head_ptr == LAST) first_lap <= 1'b0;
      if (push_ok) tail_ptr <= tail_ptr + ADDR_W'(1);
      count <= count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
    end
  end
`ifdef NULL_PAGES_ERR_EN
  // latch any rejected pop or push until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err | (pop_head && !pop_ok) | (push_tail && !push_ok);
  end
`endif
endmodule

// File: tb/tb_null_pages_fifo.sv
// tb_null_pages_fifo: directed vectors with a queued scoreboard checked at the falling edge
module tb_null_pages_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pop_head = 1'b0;
  logic        push_tail = 1'b0;
  logic [10:0] tail_addr = '0;
  logic [10:0] head_addr;
  logic        empty;
  logic [11:0] count;
  logic        err;
  logic        exp_err = 1'b0;

  typedef struct {
    string       name;
    logic        chk_head;
    logic [10:0] head;
    logic [11:0] cnt;
    logic        err_e;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  null_pages_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pop_head  (pop_head),
    .head_addr (head_addr),
    .push_tail (push_tail),
    .tail_addr (tail_addr),
    .empty     (empty),
    .count     (count)
`ifdef NULL_PAGES_ERR_EN
    ,.err      (err)
`endif
  );

`ifndef NULL_PAGES_ERR_EN
  assign err = 1'b0;
`endif

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      n_vec++;
      if (count !== x.cnt) begin
        n_bad++;
        $display("FAIL %s count: got %0d expected %0d", x.name, count, x.cnt);
      end
      if (empty !== (x.cnt == 12'd0)) begin
        n_bad++;
        $display("FAIL %s empty: got %b expected %b", x.name, empty, x.cnt == 12'd0);
      end
      if (x.chk_head && head_addr !== x.head) begin
        n_bad++;
        $display("FAIL %s head_addr: got 0x%0h expected 0x%0h", x.name, head_addr, x.head);
      end
`ifdef NULL_PAGES_ERR_EN
      if (err !== x.err_e) begin
        n_bad++;
        $display("FAIL %s err: got %b expected %b", x.name, err, x.err_e);
      end
`endif
    end
  end

  task automatic step(input string nm, input logic p, input logic u, input logic [10:0] ta,
                      input logic ch, input logic [10:0] h, input logic [11:0] c);
    @(negedge clk);
    #1;
    pop_head  = p;
    push_tail = u;
    tail_addr = ta;
    q.push_back('{nm, ch, h, c, exp_err});
  endtask

  task automatic reset_pulse(input string nm, input logic p);
    @(negedge clk);
    #1;
    rst_n    = 1'b0;
    pop_head = p;
    push_tail = 1'b0;
    exp_err  = 1'b0;
    q.push_back('{nm, 1'b1, 11'd0, 12'd2048, 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_pulse("reset", 1'b0);
    for (int k = 1; k <= 6; k++) step("pop_run", 1, 0, 0, 1, 11'(k), 12'(2048 - k));
    for (int k = 0; k < 4; k++)  step("push_run", 0, 1, 11'(k), 1, 11'd6, 12'(2043 + k));
    for (int j = 1; j <= 2041; j++) step("lap_pop", 1, 0, 0, 1, 11'(6 + j), 12'(2046 - j));
    step("wrap_pop0", 1, 0, 0, 1, 11'd0, 12'd4);
    step("wrap_pop1", 1, 0, 0, 1, 11'd1, 12'd3);
    step("wrap_pop2", 1, 0, 0, 1, 11'd2, 12'd2);
    step("wrap_pop3", 1, 0, 0, 1, 11'd3, 12'd1);
    step("drain", 1, 0, 0, 0, 11'd0, 12'd0);
    exp_err = 1'b1;
    step("pop_empty", 1, 0, 0, 0, 11'd0, 12'd0);
    step("push_pop_empty", 1, 1, 11'h5A5, 1, 11'h5A5, 12'd1);
    step("hold", 0, 0, 0, 1, 11'h5A5, 12'd1);
    reset_pulse("reset2", 1'b0);
    exp_err = 1'b1;
    step("push_full", 0, 1, 11'h123, 1, 11'd0, 12'd2048);
    step("push_pop_full", 1, 1, 11'd7, 1, 11'd1, 12'd2048);
    step("pop_more", 1, 0, 0, 1, 11'd2, 12'd2047);
    reset_pulse("reset_mid", 1'b1);
    for (int k = 1; k <= 3; k++) step("post_reset_pop", 1, 0, 0, 1, 11'(k), 12'(2048 - k));
    step("idle", 0, 0, 0, 1, 11'd3, 12'd2045);
    @(negedge clk);
    #1;
    pop_head = 1'b0;
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
